// File: rtl/lfsr_checker.sv
// Serial checker for the 16-bit Fibonacci LFSR stream (taps 16/14/13/11).
// It hunts for 16 bits of history, verifies the recurrence, and then
// free-runs a local reference to count bit errors while locked.

module lfsr_checker #(
    parameter int unsigned LOCK_MATCHES = 16,
    parameter int unsigned LOSS_ERRORS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear_count,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    localparam logic [8:0] LockThr = 9'(LOCK_MATCHES);
    localparam logic [8:0] LossThr = 9'(LOSS_ERRORS);

    state_e      state_q, state_d;
    logic [15:0] hist_q, hist_d;
    logic [4:0]  fill_cnt_q, fill_cnt_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [7:0]  consec_err_q, consec_err_d;
    logic [15:0] err_count_q, err_count_d;
    logic        err_pulse_q, err_pulse_d;
    logic        locked_q, locked_d;

    logic        pred;
    logic [8:0]  match_inc;
    logic [8:0]  consec_inc;
    logic        lock_miss;

    // hist[k] holds b[n-1-k], so the taps are b[n-16], b[n-14], b[n-13], b[n-11]
    assign pred       = hist_q[15] ^ hist_q[13] ^ hist_q[12] ^ hist_q[10];
    assign match_inc  = {1'b0, match_cnt_q} + 9'd1;
    assign consec_inc = {1'b0, consec_err_q} + 9'd1;
    assign lock_miss  = in_valid && (state_q == StLocked) && (in_bit != pred);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHunt;
            hist_q       <= '0;
            fill_cnt_q   <= '0;
            match_cnt_q  <= '0;
            consec_err_q <= '0;
            err_count_q  <= '0;
            err_pulse_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            fill_cnt_q   <= fill_cnt_d;
            match_cnt_q  <= match_cnt_d;
            consec_err_q <= consec_err_d;
            err_count_q  <= err_count_d;
            err_pulse_q  <= err_pulse_d;
            locked_q     <= locked_d;
        end
    end

    // Next-state and counter update; everything holds when in_valid is low
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        fill_cnt_d   = fill_cnt_q;
        match_cnt_d  = match_cnt_q;
        consec_err_d = consec_err_q;
        err_count_d  = err_count_q;

        case (state_q)
            StHunt: begin
                if (in_valid) begin
                    hist_d     = {hist_q[14:0], in_bit};
                    fill_cnt_d = fill_cnt_q + 5'd1;
                    if (fill_cnt_q == 5'd15) begin
                        state_d     = StVerify;
                        match_cnt_d = '0;
                    end
                end
            end
            StVerify: begin
                if (in_valid) begin
                    hist_d = {hist_q[14:0], in_bit};
                    // An all-zero history trivially predicts 0; never trust it
                    if ((in_bit == pred) && (hist_q != '0)) begin
                        match_cnt_d = match_inc[7:0];
                        if (match_inc >= LockThr) begin
                            state_d = StLocked;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
            StLocked: begin
                if (in_valid) begin
                    // Reference free-runs on its own prediction, immune to line errors
                    hist_d = {hist_q[14:0], pred};
                    if (in_bit != pred) begin
                        consec_err_d = consec_inc[7:0];
                        if (consec_inc >= LossThr) begin
                            state_d      = StHunt;
                            fill_cnt_d   = '0;
                            match_cnt_d  = '0;
                            consec_err_d = '0;
                        end
                    end else begin
                        consec_err_d = '0;
                    end
                end
            end
            default: begin
                // Unused encoding recovers to acquisition
                state_d      = StHunt;
                fill_cnt_d   = '0;
                match_cnt_d  = '0;
                consec_err_d = '0;
            end
        endcase

        if (clear_count) begin
            err_count_d = lock_miss ? 16'd1 : 16'd0;
        end else if (lock_miss && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Registered-output next values, aligned with the state transition
    always_comb begin
        err_pulse_d = lock_miss;
        locked_d    = (state_d == StLocked);
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus pushes the expected outputs
// for each clock edge, a monitor pops and compares them after the edge.

module tb_lfsr_checker;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        clear_count;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    lfsr_checker #(
        .LOCK_MATCHES(16),
        .LOSS_ERRORS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .clear_count(clear_count),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .state      (state)
    );

    localparam logic [3:0] MNone = 4'b0000;
    localparam logic [3:0] MAll  = 4'b1111;

    typedef struct {
        string       name;
        logic [3:0]  mask;   // [3] state, [2] locked, [1] err_pulse, [0] err_count
        logic [1:0]  st;
        logic        lk;
        logic        pl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    int          total  = 0;
    int          passes = 0;
    logic [15:0] g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h, want %h", n, got, want);
    endtask

    // Monitor: outputs are registered, so every edge presents a new result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[3]) cmp({e.name, ".state"}, {14'd0, state}, {14'd0, e.st});
                if (e.mask[2]) cmp({e.name, ".locked"}, {15'd0, locked}, {15'd0, e.lk});
                if (e.mask[1]) cmp({e.name, ".err_pulse"}, {15'd0, err_pulse}, {15'd0, e.pl});
                if (e.mask[0]) cmp({e.name, ".err_count"}, err_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    // Generator: same recurrence as the transmitter, g holds the last 16 bits
    task automatic gen(output logic b);
        b = g[15] ^ g[13] ^ g[12] ^ g[10];
        g = {g[14:0], b};
    endtask

    task automatic step(input logic v, input logic b, input logic clr, input logic rst,
                        input string n, input logic [3:0] m, input logic [1:0] s,
                        input logic l, input logic p, input logic [15:0] c);
        in_valid    = v;
        in_bit      = b;
        clear_count = clr;
        reset       = rst;
        @(posedge clk);
        q.push_back('{n, m, s, l, p, c});
        #1;
    endtask

    task automatic gbit(input logic inv, input string n, input logic [3:0] m,
                        input logic [1:0] s, input logic l, input logic p,
                        input logic [15:0] c);
        logic b;
        gen(b);
        step(1'b1, b ^ inv, 1'b0, 1'b0, n, m, s, l, p, c);
    endtask

    // Expected state after the i-th valid bit of an acquisition from HUNT
    function automatic logic [1:0] acq_state(input int i);
        if (i < 16) return 2'd0;
        if (i < 32) return 2'd1;
        return 2'd2;
    endfunction

    initial begin
        logic b;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        clear_count = 1'b0;
        g           = 16'hACE1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, "rst0", MAll, 2'd0, 1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, "rst1", MAll, 2'd0, 1'b0, 1'b0, 16'd0);

        // Acquisition: VERIFY after bit 16, LOCKED after bit 32
        for (int i = 1; i <= 32; i++) begin
            gbit(1'b0, "acq", MAll, acq_state(i), (i >= 32), 1'b0, 16'd0);
        end
        for (int i = 0; i < 1000; i++) begin
            gbit(1'b0, "run", MAll, 2'd2, 1'b1, 1'b0, 16'd0);
        end

        // Single error: one pulse, count 1, still locked
        gbit(1'b1, "single_err", MAll, 2'd2, 1'b1, 1'b1, 16'd1);
        for (int i = 0; i < 5; i++) begin
            gbit(1'b0, "single_after", MAll, 2'd2, 1'b1, 1'b0, 16'd1);
        end

        // Clear on an idle cycle: count zeroed, state untouched
        step(1'b0, 1'b1, 1'b1, 1'b0, "idle_clr", MAll, 2'd2, 1'b1, 1'b0, 16'd0);

        // Loss of lock after 4 consecutive errors
        gbit(1'b1, "loss1", MAll, 2'd2, 1'b1, 1'b1, 16'd1);
        gbit(1'b1, "loss2", MAll, 2'd2, 1'b1, 1'b1, 16'd2);
        gbit(1'b1, "loss3", MAll, 2'd2, 1'b1, 1'b1, 16'd3);
        gbit(1'b1, "loss4", MAll, 2'd0, 1'b0, 1'b1, 16'd4);
        for (int i = 1; i <= 32; i++) begin
            gbit(1'b0, "relock", MAll, acq_state(i), (i >= 32), 1'b0, 16'd4);
        end

        // Clear coinciding with a counted error
        gen(b);
        step(1'b1, ~b, 1'b1, 1'b0, "err_clr", MAll, 2'd2, 1'b1, 1'b1, 16'd1);

        // Reset while locked restarts from HUNT
        gen(b);
        step(1'b1, b, 1'b1, 1'b1, "rst_locked", MAll, 2'd0, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "rst_hold", MAll, 2'd0, 1'b0, 1'b0, 16'd0);

        // Gapped acquisition: valid alternates, lock after exactly 32 valid bits
        g = 16'hACE1;
        for (int i = 1; i <= 32; i++) begin
            gbit(1'b0, "gap_v", MAll, acq_state(i), (i >= 32), 1'b0, 16'd0);
            step(1'b0, 1'b1, 1'b0, 1'b0, "gap_idle", MAll, acq_state(i), (i >= 32),
                 1'b0, 16'd0);
        end

        // Stuck-at-0 stream never locks
        step(1'b0, 1'b0, 1'b0, 1'b1, "stuck_rst", MAll, 2'd0, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i <= 500; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, "stuck", MAll, (i < 16) ? 2'd0 : 2'd1, 1'b0,
                 1'b0, 16'd0);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, "tail", MNone, 2'd0, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_MATCHES, default 16, meaning the number of consecutive correct predictions required to declare lock (legal range 1..255).
REQ-002 The block SHALL have parameter LOSS_ERRORS, default 4, meaning the number of consecutive mismatches while locked that forces loss of lock (legal range 1..255).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  qualifies in_bit for the current cycle.
REQ-006 in_bit  input  1  serial stream under test, the feedback-bit output of the 16-bit Fibonacci LFSR generator.
REQ-007 clear_count  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  high while state is LOCKED.
REQ-009 err_pulse  output  1  one-cycle flag marking a mismatch detected while LOCKED.
REQ-010 err_count  output  16  saturating count of mismatches detected while LOCKED.
REQ-011 state  output  2  current state: HUNT=0, VERIFY=1, LOCKED=2; 3 is unused.

Function
REQ-012 Stream polynomial SHALL match the generator: b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11].
REQ-013 History register hist[15:0] SHALL hold the last 16 accepted bits, with hist[k] = b[n-1-k].
REQ-014 Predicted bit SHALL be pred = hist[15] ^ hist[13] ^ hist[12] ^ hist[10].
REQ-015 On a cycle with in_valid low, all registers SHALL hold and err_pulse SHALL be 0.
REQ-016 HUNT, on each valid bit:
  - shift in_bit into hist[0];
  - increment fill_cnt;
  - on the 16th valid bit, enter VERIFY with match_cnt=0.
REQ-017 VERIFY, on each valid bit:
  - shift in_bit into hist;
  - if in_bit==pred and hist!=0: increment match_cnt, and enter LOCKED when match_cnt reaches LOCK_MATCHES;
  - otherwise: set match_cnt=0 and remain in VERIFY.
REQ-018 The all-zero history SHALL never count as a match, so a stuck-at-0 stream never locks.
REQ-019 LOCKED, on each valid bit:
  - shift pred (not in_bit) into hist, so hist free-runs as the reference;
  - mismatch when in_bit!=pred.
REQ-020 A LOCKED mismatch SHALL:
  - assert err_pulse in the following cycle;
  - increment err_count, saturating at 16'hFFFF;
  - increment consec_err.
REQ-021 A LOCKED match SHALL clear consec_err to 0.
REQ-022 When consec_err reaches LOSS_ERRORS, the block SHALL enter HUNT, clearing fill_cnt, match_cnt and consec_err. The error that triggered the transition is still counted and pulsed.
REQ-023 locked, state and err_pulse SHALL be registered outputs, updated on the same edge as the state transition.
REQ-024 A single bit error while locked SHALL produce exactly one err_pulse.
REQ-025 clear_count SHALL zero err_count. If it coincides with a counted mismatch, err_count SHALL become 1.
REQ-026 clear_count SHALL NOT affect state, hist or err_pulse.
REQ-027 Counter widths:
  - fill_cnt: 5 bits;
  - match_cnt, consec_err: 8 bits;
  - no counter may wrap.
REQ-028 State encoding 3 SHALL recover to HUNT on the next edge.

Reset
REQ-029 While reset is high on a rising edge, the block SHALL set:
  - state=HUNT, hist=0, fill_cnt=0, match_cnt=0, consec_err=0;
  - locked=0, err_pulse=0, err_count=0.
REQ-030 Reset SHALL take priority over in_valid and clear_count.
REQ-031 Reset asserted mid-operation, including while LOCKED, SHALL restart acquisition from HUNT.

Verification
REQ-032 Acquisition: generator seeded 16'hACE1, in_valid=1 continuously, default parameters -> state=VERIFY after bit 16; locked=1 after bit 32; err_count=0 over 1000 further bits.
REQ-033 Single error: once locked, invert one bit -> exactly one err_pulse; err_count=1; locked stays 1.
REQ-034 Loss of lock: once locked, invert 4 consecutive bits -> err_count=4; state=HUNT after the 4th; relock 32 valid bits later.
REQ-035 Stuck stream: in_bit=0 for 500 valid cycles -> locked never asserts; state remains VERIFY.
REQ-036 Gaps and clear:
  - in_valid toggled 1,0,1,0 during acquisition -> lock after exactly 32 valid bits;
  - clear_count on the same cycle as an error -> err_count=1.
REQ-037 Reset while locked -> next cycle state=HUNT, locked=0, err_count=0.
